prog_matched_filter: RTL and testbench

- Next-generation, parametrised single-channel SSR matched filter for PUEO.
- Replaces fixed hard-coded tap arithmetic with a runtime-loadable signed coefficient set of arbitrary length.
- Coefficients are double-buffered and committed atomically on a frame-sync boundary.
- Sits after the per-channel sample stream and before the trigger/beamforming logic; one instance per channel.

---
 rtl/prog_matched_filter.sv | 182 ++++++++++++++++++
 tb/tb_prog_matched_filter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_matched_filter.sv
// prog_matched_filter: single-channel SSR FIR matched filter with a double-buffered, runtime-loadable coefficient bank.
// Define PROG_MATCHED_FILTER_SAT_EN for per-lane output saturation, sat_o and one extra output stage.
module prog_matched_filter #(
   parameter int NBITS      = 12,
   parameter int NSAMPS     = 8,
   parameter int NTAPS      = 42,
   parameter int COEFF_BITS = 4,
   parameter int OUT_BITS   = 18
) (
   input  logic                       aclk,
   input  logic                       arst,
   input  logic [NBITS*NSAMPS-1:0]    data_i,
   input  logic                       data_valid_i,
   output logic [OUT_BITS*NSAMPS-1:0] data_o,
   output logic                       data_valid_o,
   output logic                       sat_o,
   input  logic                       coeff_wr,
   input  logic [$clog2(NTAPS)-1:0]   coeff_addr,
   input  logic [COEFF_BITS-1:0]      coeff_data,
   input  logic                       coeff_commit,
   input  logic                       frame_sync_i,
   output logic                       coeff_busy,
   output logic                       coeff_wr_err
);

   localparam int ACC_BITS = NBITS + COEFF_BITS + $clog2(NTAPS);
   localparam int TREE     = $clog2(NTAPS);
   localparam int LEAVES   = 1 << TREE;
   localparam int HIST     = (NTAPS - 1 + NSAMPS - 1) / NSAMPS;
   localparam int WIN      = (HIST + 1) * NSAMPS;
`ifdef PROG_MATCHED_FILTER_SAT_EN
   localparam int LAT      = 3 + TREE;
`else
   localparam int LAT      = 2 + TREE;
`endif

   typedef enum logic {IDLE, PEND} ld_state_t;

   ld_state_t                     state;
   logic signed [COEFF_BITS-1:0]  shadow  [NTAPS];
   logic signed [COEFF_BITS-1:0]  active  [NTAPS];
   logic signed [COEFF_BITS-1:0]  coef_s0 [NTAPS];
   logic signed [NBITS-1:0]       win     [WIN];
   logic signed [ACC_BITS-1:0]    node    [NSAMPS][1:2*LEAVES-1];
   logic [LAT:0]                  vpipe;

   // Loader: shadow writes only while IDLE; active bank swaps on frame sync while PEND.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state        <= IDLE;
         coeff_busy   <= 1'b0;
         coeff_wr_err <= 1'b0;
         for (int unsigned k = 0; k < NTAPS; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
         end
      end else begin
         coeff_wr_err <= 1'b0;
         case (state)
            IDLE: begin
               if (coeff_wr) begin
                  if (32'(coeff_addr) < NTAPS)
                     shadow[coeff_addr] <= coeff_data;
                  else
                     coeff_wr_err <= 1'b1;
               end
               if (coeff_commit) begin
                  state      <= PEND;
                  coeff_busy <= 1'b1;
               end
            end
            PEND: begin
               if (coeff_wr)
                  coeff_wr_err <= 1'b1;
               if (frame_sync_i) begin
                  for (int unsigned k = 0; k < NTAPS; k++)
                     active[k] <= shadow[k];
                  state      <= IDLE;
                  coeff_busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stage 0: sample window (history + current beat) and a snapshot of the bank that travels with it.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         for (int unsigned j = 0; j < WIN; j++)
            win[j] <= '0;
         for (int unsigned k = 0; k < NTAPS; k++)
            coef_s0[k] <= '0;
      end else if (data_valid_i) begin
         for (int unsigned j = 0; j < HIST * NSAMPS; j++)
            win[j] <= win[j + NSAMPS];
         for (int unsigned i = 0; i < NSAMPS; i++)
            win[HIST * NSAMPS + i] <= data_i[NBITS*i +: NBITS];
         for (int unsigned k = 0; k < NTAPS; k++)
            coef_s0[k] <= active[k];
      end
   end

   // Heap-ordered tree per lane: leaves are registered products, each inner node sums its children a cycle later.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         for (int unsigned i = 0; i < NSAMPS; i++)
            for (int unsigned n = 1; n < 2 * LEAVES; n++)
               node[i][n] <= '0;
      end else begin
         for (int unsigned i = 0; i < NSAMPS; i++) begin
            for (int unsigned k = 0; k < NTAPS; k++)
               node[i][LEAVES + k] <= ACC_BITS'(win[HIST * NSAMPS + i - k]) * ACC_BITS'(coef_s0[k]);
            for (int unsigned k = NTAPS; k < LEAVES; k++)
               node[i][LEAVES + k] <= '0;
            for (int unsigned n = 1; n < LEAVES; n++)
               node[i][n] <= node[i][2 * n] + node[i][2 * n + 1];
         end
      end
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst)
         vpipe <= '0;
      else
         vpipe <= {vpipe[LAT-1:0], data_valid_i};
   end

   assign data_valid_o = vpipe[LAT];

`ifdef PROG_MATCHED_FILTER_SAT_EN
   localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
   localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;

   logic [OUT_BITS*NSAMPS-1:0] clip_data;
   logic                       clip_any;
   logic [OUT_BITS*NSAMPS-1:0] sat_data;
   logic                       sat_any;

   always_comb begin
      clip_data = '0;
      clip_any  = 1'b0;
      for (int unsigned i = 0; i < NSAMPS; i++) begin
         if (node[i][1] > SAT_MAX) begin
            clip_data[OUT_BITS*i +: OUT_BITS] = SAT_MAX[OUT_BITS-1:0];
            clip_any = 1'b1;
         end else if (node[i][1] < SAT_MIN) begin
            clip_data[OUT_BITS*i +: OUT_BITS] = SAT_MIN[OUT_BITS-1:0];
            clip_any = 1'b1;
         end else begin
            clip_data[OUT_BITS*i +: OUT_BITS] = node[i][1][OUT_BITS-1:0];
         end
      end
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         sat_data <= '0;
         sat_any  <= 1'b0;
         data_o   <= '0;
         sat_o    <= 1'b0;
      end else begin
         sat_data <= clip_data;
         sat_any  <= clip_any;
         data_o   <= sat_data;
         sat_o    <= sat_any & vpipe[LAT-1];
      end
   end
`else
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         data_o <= '0;
      end else begin
         for (int unsigned i = 0; i < NSAMPS; i++)
            data_o[OUT_BITS*i +: OUT_BITS] <= node[i][1][OUT_BITS-1:0];
      end
   end

   assign sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_prog_matched_filter.sv
// Directed self-checking bench for prog_matched_filter: impulse, valid gaps, atomic bank swap, rejects, reset, wrap/saturation.
module tb_prog_matched_filter;

   localparam int NBITS      = 12;
   localparam int NSAMPS     = 8;
   localparam int NTAPS      = 42;
   localparam int COEFF_BITS = 4;
   localparam int OUT_BITS   = 18;
   localparam int AW         = $clog2(NTAPS);
   localparam int W          = OUT_BITS * NSAMPS;
   localparam int DW         = NBITS * NSAMPS;
`ifdef PROG_MATCHED_FILTER_SAT_EN
   localparam int LAT        = 9;
`else
   localparam int LAT        = 8;
`endif

   logic                  aclk = 1'b0;
   logic                  arst;
   logic [DW-1:0]         data_i;
   logic                  data_valid_i;
   logic [W-1:0]          data_o;
   logic                  data_valid_o;
   logic                  sat_o;
   logic                  coeff_wr;
   logic [AW-1:0]         coeff_addr;
   logic [COEFF_BITS-1:0] coeff_data;
   logic                  coeff_commit;
   logic                  frame_sync_i;
   logic                  coeff_busy;
   logic                  coeff_wr_err;

   int n_cmp  = 0;
   int n_fail = 0;

   prog_matched_filter #(
      .NBITS      (NBITS),
      .NSAMPS     (NSAMPS),
      .NTAPS      (NTAPS),
      .COEFF_BITS (COEFF_BITS),
      .OUT_BITS   (OUT_BITS)
   ) dut (
      .aclk         (aclk),
      .arst         (arst),
      .data_i       (data_i),
      .data_valid_i (data_valid_i),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .sat_o        (sat_o),
      .coeff_wr     (coeff_wr),
      .coeff_addr   (coeff_addr),
      .coeff_data   (coeff_data),
      .coeff_commit (coeff_commit),
      .frame_sync_i (frame_sync_i),
      .coeff_busy   (coeff_busy),
      .coeff_wr_err (coeff_wr_err)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++)
         tick();
   endtask

   task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic wr_coef(input int addr, input int val, input logic with_commit);
      coeff_wr     = 1'b1;
      coeff_addr   = AW'(addr);
      coeff_data   = COEFF_BITS'(val);
      coeff_commit = with_commit;
      tick();
      coeff_wr     = 1'b0;
      coeff_commit = 1'b0;
   endtask

   function automatic logic [W-1:0] lanes_all(input int v);
      logic [W-1:0] r = '0;
      for (int i = 0; i < NSAMPS; i++)
         r[i*OUT_BITS +: OUT_BITS] = OUT_BITS'(v);
      return r;
   endfunction

   function automatic logic [W-1:0] lane_one(input int idx, input int v);
      logic [W-1:0] r = '0;
      r[idx*OUT_BITS +: OUT_BITS] = OUT_BITS'(v);
      return r;
   endfunction

   function automatic logic [DW-1:0] din_all(input int v);
      logic [DW-1:0] r = '0;
      for (int i = 0; i < NSAMPS; i++)
         r[i*NBITS +: NBITS] = NBITS'(v);
      return r;
   endfunction

   function automatic logic [DW-1:0] din_one(input int idx, input int v);
      logic [DW-1:0] r = '0;
      r[idx*NBITS +: NBITS] = NBITS'(v);
      return r;
   endfunction

   initial begin
      logic [W-1:0] e;

      arst = 1'b1;
      data_i = '0;
      data_valid_i = 1'b0;
      coeff_wr = 1'b0;
      coeff_addr = '0;
      coeff_data = '0;
      coeff_commit = 1'b0;
      frame_sync_i = 1'b0;
      ticks(3);
      check_vec("rst_data", data_o, '0);
      check_bit("rst_valid", data_valid_o, 1'b0);
      check_bit("rst_busy", coeff_busy, 1'b0);
      check_bit("rst_err", coeff_wr_err, 1'b0);
      check_bit("rst_sat", sat_o, 1'b0);
      arst = 1'b0;
      tick();

      // Impulse with h[0]=3, h[1]=-2
      wr_coef(0, 3, 1'b0);
      check_bit("t1_wr_ok", coeff_wr_err, 1'b0);
      wr_coef(1, -2, 1'b0);
      coeff_commit = 1'b1;
      tick();
      coeff_commit = 1'b0;
      check_bit("t1_busy_set", coeff_busy, 1'b1);
      frame_sync_i = 1'b1;
      tick();
      frame_sync_i = 1'b0;
      check_bit("t1_busy_clr", coeff_busy, 1'b0);
      data_i = din_one(7, 100);
      data_valid_i = 1'b1;
      tick();
      data_i = '0;
      tick();
      data_valid_i = 1'b0;
      ticks(LAT - 2);
      check_bit("t1_valid_early", data_valid_o, 1'b0);
      tick();
      check_bit("t1_valid_lat", data_valid_o, 1'b1);
      check_vec("t1_beat0", data_o, lane_one(7, 300));
      check_bit("t1_sat0", sat_o, 1'b0);
      tick();
      check_bit("t1_valid_b1", data_valid_o, 1'b1);
      check_vec("t1_beat1", data_o, lane_one(0, -200));
      tick();
      check_bit("t1_valid_end", data_valid_o, 1'b0);

      // Invalid cycles between beats must not advance history
      data_i = din_one(7, 100);
      data_valid_i = 1'b1;
      tick();
      data_valid_i = 1'b0;
      data_i = '0;
      ticks(5);
      data_valid_i = 1'b1;
      tick();
      data_valid_i = 1'b0;
      ticks(LAT - 6);
      check_bit("t2_valid_a", data_valid_o, 1'b1);
      check_vec("t2_beat_a", data_o, lane_one(7, 300));
      ticks(3);
      check_bit("t2_gap_valid", data_valid_o, 1'b0);
      check_vec("t2_gap_stable", data_o, lane_one(7, 300));
      ticks(3);
      check_bit("t2_valid_b", data_valid_o, 1'b1);
      check_vec("t2_beat_b", data_o, lane_one(0, -200));

      // Atomic swap from bank A (+1) to bank B (-1) mid-stream
      for (int k = 0; k < NTAPS; k++)
         wr_coef(k, 1, k == NTAPS - 1);
      check_bit("t3_busy_a", coeff_busy, 1'b1);
      frame_sync_i = 1'b1;
      tick();
      frame_sync_i = 1'b0;
      check_bit("t3_idle_a", coeff_busy, 1'b0);
      data_i = din_all(1);
      data_valid_i = 1'b1;
      for (int k = 0; k < NTAPS; k++)
         wr_coef(k, -1, k == NTAPS - 1);
      check_bit("t3_busy_b", coeff_busy, 1'b1);
      tick();
      check_bit("t3_busy_hold", coeff_busy, 1'b1);
      frame_sync_i = 1'b1;
      tick();
      frame_sync_i = 1'b0;
      check_bit("t3_idle_b", coeff_busy, 1'b0);
      ticks(LAT - 2);
      check_vec("t3_bank_a_0", data_o, lanes_all(42));
      tick();
      check_vec("t3_bank_a_1", data_o, lanes_all(42));
      tick();
      check_bit("t3_valid_last_a", data_valid_o, 1'b1);
      check_vec("t3_bank_a_last", data_o, lanes_all(42));
      tick();
      check_vec("t3_bank_b_first", data_o, lanes_all(-42));
      tick();
      check_vec("t3_bank_b_next", data_o, lanes_all(-42));
      data_valid_i = 1'b0;
      data_i = '0;

      // Rejected writes: during PEND and out-of-range address
      wr_coef(0, 5, 1'b0);
      check_bit("t4_wr_ok", coeff_wr_err, 1'b0);
      coeff_commit = 1'b1;
      tick();
      coeff_commit = 1'b0;
      check_bit("t4_busy", coeff_busy, 1'b1);
      wr_coef(1, 7, 1'b1);
      check_bit("t4_err_pend", coeff_wr_err, 1'b1);
      tick();
      check_bit("t4_err_pend_clr", coeff_wr_err, 1'b0);
      check_bit("t4_busy_hold", coeff_busy, 1'b1);
      frame_sync_i = 1'b1;
      tick();
      frame_sync_i = 1'b0;
      check_bit("t4_idle", coeff_busy, 1'b0);
      wr_coef(NTAPS, 7, 1'b0);
      check_bit("t4_err_addr", coeff_wr_err, 1'b1);
      tick();
      check_bit("t4_err_addr_clr", coeff_wr_err, 1'b0);
      coeff_commit = 1'b1;
      frame_sync_i = 1'b1;
      tick();
      coeff_commit = 1'b0;
      frame_sync_i = 1'b0;
      check_bit("t4_commit_sync_same", coeff_busy, 1'b1);
      frame_sync_i = 1'b1;
      tick();
      frame_sync_i = 1'b0;
      check_bit("t4_idle2", coeff_busy, 1'b0);
      data_i = '0;
      data_valid_i = 1'b1;
      ticks(6);
      data_i = din_one(0, 10);
      tick();
      data_valid_i = 1'b0;
      data_i = '0;
      ticks(LAT);
      check_bit("t4_valid", data_valid_o, 1'b1);
      e = lanes_all(-10);
      e[0 +: OUT_BITS] = OUT_BITS'(50);
      check_vec("t4_bank", data_o, e);

      // Reset during PEND with the pipeline busy
      data_i = din_all(1);
      data_valid_i = 1'b1;
      ticks(LAT + 2);
      check_bit("t5_pre_valid", data_valid_o, 1'b1);
      coeff_commit = 1'b1;
      tick();
      coeff_commit = 1'b0;
      check_bit("t5_pre_busy", coeff_busy, 1'b1);
      #2;
      arst = 1'b1;
      #1;
      check_vec("t5_rst_data", data_o, '0);
      check_bit("t5_rst_valid", data_valid_o, 1'b0);
      check_bit("t5_rst_busy", coeff_busy, 1'b0);
      check_bit("t5_rst_err", coeff_wr_err, 1'b0);
      check_bit("t5_rst_sat", sat_o, 1'b0);
      data_valid_i = 1'b0;
      data_i = '0;
      ticks(2);
      arst = 1'b0;
      frame_sync_i = 1'b1;
      tick();
      frame_sync_i = 1'b0;
      check_bit("t5_idle_after", coeff_busy, 1'b0);
      data_i = din_one(0, 100);
      data_valid_i = 1'b1;
      tick();
      data_valid_i = 1'b0;
      data_i = '0;
      ticks(LAT);
      check_bit("t5_valid", data_valid_o, 1'b1);
      check_vec("t5_zero_bank", data_o, '0);

      // Large constant input: wrap without the macro, clip with it
      for (int k = 0; k < NTAPS; k++)
         wr_coef(k, 4, k == NTAPS - 1);
      frame_sync_i = 1'b1;
      tick();
      frame_sync_i = 1'b0;
      data_i = din_all(2047);
      data_valid_i = 1'b1;
      ticks(10);
      data_valid_i = 1'b0;
      ticks(LAT);
      check_bit("t6_valid", data_valid_o, 1'b1);
`ifdef PROG_MATCHED_FILTER_SAT_EN
      check_vec("t6_clip", data_o, lanes_all(131071));
      check_bit("t6_sat", sat_o, 1'b1);
`else
      check_vec("t6_wrap", data_o, lanes_all(81752));
      check_bit("t6_sat", sat_o, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
